// File: rtl/writeback_queue.sv
// rtl/writeback_queue.sv - write-back FIFO with dest decode and forwarding lookup
// Optional statistics counters are enabled by defining WB_STATS_EN.
module writeback_queue #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  input  logic [DW-1:0] in_result,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic          rf_ready,
  input  logic [AW-1:0] fwd_addr1,
  input  logic [AW-1:0] fwd_addr2,
  output logic          fwd_hit1,
  output logic          fwd_hit2,
  output logic [DW-1:0] fwd_data1,
  output logic [DW-1:0] fwd_data2
`ifdef WB_STATS_EN
  ,
  output logic [31:0]   wb_count,
  output logic [31:0]   drop_count
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr_n, idx;
  logic [CW-1:0] count, count_n;
  logic [AW-1:0] dest, head_addr_n;
  logic [DW-1:0] head_data_n;
  logic          has_dest, accept, push, pop;
  logic          unused_instr_bits;

  assign unused_instr_bits = ^{in_instr[25:21], in_instr[10:6]};

  always_comb begin
    dest = '0;
    case (in_instr[31:26])
      6'h00: if (in_instr[5:0] != 6'h08) dest = in_instr[11+AW-1:11];
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: dest = in_instr[16+AW-1:16];
      default: dest = '0;
    endcase
  end

  assign has_dest = (dest != '0);
  assign in_ready = (count != CW'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign push     = accept && has_dest;
  assign pop      = rf_we && rf_ready;
  assign rd_ptr_n = pop ? rd_ptr + PW'(1) : rd_ptr;

  always_comb begin
    count_n = count;
    if (push && !pop)      count_n = count + CW'(1);
    else if (!push && pop) count_n = count - CW'(1);
  end

  // Pick up the head for the next cycle; a push into an otherwise empty queue bypasses storage.
  always_comb begin
    head_addr_n = '0;
    head_data_n = '0;
    if (count_n != '0) begin
      if (push && (wr_ptr == rd_ptr_n)) begin
        head_addr_n = dest;
        head_data_n = in_result;
      end else begin
        head_addr_n = mem_addr[rd_ptr_n];
        head_data_n = mem_data[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr] <= dest;
      mem_data[wr_ptr] <= in_result;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rd_ptr   <= rd_ptr_n;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      count    <= count_n;
      rf_we    <= (count_n != '0);
      rf_waddr <= head_addr_n;
      rf_wdata <= head_data_n;
    end
  end

  // Oldest to youngest, so the last match wins and yields the youngest pending data.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_hit2  = 1'b0;
    fwd_data1 = '0;
    fwd_data2 = '0;
    idx       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if (CW'(k) < count) begin
        if (fwd_addr1 != '0 && mem_addr[idx] == fwd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = mem_data[idx];
        end
        if (fwd_addr2 != '0 && mem_addr[idx] == fwd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = mem_data[idx];
        end
      end
    end
  end

`ifdef WB_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_count   <= '0;
      drop_count <= '0;
    end else begin
      if (pop) wb_count <= wb_count + 32'd1;
      if (accept && !has_dest) drop_count <= drop_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb/tb_writeback_queue.sv - directed self-checking bench for writeback_queue
module tb_writeback_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_result = '0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        rf_ready = 1'b0;
  logic [4:0]  fwd_addr1 = '0;
  logic [4:0]  fwd_addr2 = '0;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`ifdef WB_STATS_EN
  logic [31:0] wb_count, drop_count;
`endif

  int checks = 0;
  int failures = 0;

  writeback_queue #(.DEPTH(2), .AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_result(in_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .rf_ready(rf_ready),
    .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
    .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2), .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`ifdef WB_STATS_EN
    , .wb_count(wb_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [5:0] funct);
    return {6'h00, 5'd1, 5'd2, rd, 5'd0, funct};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt);
    return {op, 5'd1, rt, 16'h0001};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%b exp=0", rf_we); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if ({fwd_hit1, fwd_hit2} !== 2'b00) begin failures++; $display("FAIL reset_fwd_hit got=%b exp=00", {fwd_hit1, fwd_hit2}); end
    checks++; if ({rf_waddr, rf_wdata} !== 37'd0) begin failures++; $display("FAIL reset_waddr_wdata got=%h/%h exp=0/0", rf_waddr, rf_wdata); end
    reset = 1'b1;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_release_rf_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_single_write();
    rf_ready = 1'b1;
    in_valid = 1'b1; in_instr = rtype(5'd3, 6'h20); in_result = 32'h2A;
    tick();
    in_valid = 1'b0;
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL single_rf_we got=%b exp=1", rf_we); end
    checks++; if (rf_waddr !== 5'd3) begin failures++; $display("FAIL single_waddr got=%0d exp=3", rf_waddr); end
    checks++; if (rf_wdata !== 32'h2A) begin failures++; $display("FAIL single_wdata got=%h exp=2a", rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL single_drain_rf_we got=%b exp=0", rf_we); end
  endtask

  task automatic test_full_stall();
    rf_ready = 1'b0;
    in_valid = 1'b1; in_instr = itype(6'h08, 5'd5); in_result = 32'h55;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_ready_one got=%b exp=1", in_ready); end
    in_instr = itype(6'h0D, 5'd6); in_result = 32'h66;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
    tick();
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h55) begin failures++; $display("FAIL full_stall_head got=%b/%0d/%h exp=1/5/55", rf_we, rf_waddr, rf_wdata); end
    // Offer a push while full and popping: it must be refused.
    rf_ready = 1'b1;
    in_valid = 1'b1; in_instr = itype(6'h08, 5'd9); in_result = 32'h99;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_pop_in_ready got=%b exp=0", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin failures++; $display("FAIL full_second_write got=%b/%0d/%h exp=1/6/66", rf_we, rf_waddr, rf_wdata); end
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL full_no_extra_push got=%b addr=%0d exp=0", rf_we, rf_waddr); end
  endtask

  task automatic test_forwarding();
    rf_ready = 1'b0;
    in_valid = 1'b1; in_instr = itype(6'h08, 5'd7); in_result = 32'h11;
    tick();
    in_instr = itype(6'h0D, 5'd7); in_result = 32'h22;
    tick();
    in_valid = 1'b0;
    fwd_addr1 = 5'd7; fwd_addr2 = 5'd0;
    #1;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin failures++; $display("FAIL fwd_youngest got=%b/%h exp=1/22", fwd_hit1, fwd_data1); end
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin failures++; $display("FAIL fwd_addr0 got=%b/%h exp=0/0", fwd_hit2, fwd_data2); end
    fwd_addr2 = 5'd5;
    #1;
    checks++; if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'h0) begin failures++; $display("FAIL fwd_miss got=%b/%h exp=0/0", fwd_hit2, fwd_data2); end
    rf_ready = 1'b1;
    #1;
    checks++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin failures++; $display("FAIL fwd_pop_cycle got=%b/%h exp=1/22", fwd_hit1, fwd_data1); end
    tick();
    fwd_addr2 = 5'd7;
    #1;
    checks++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'h22) begin failures++; $display("FAIL fwd_one_left got=%b/%h exp=1/22", fwd_hit2, fwd_data2); end
    tick();
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin failures++; $display("FAIL fwd_empty got=%b/%h exp=0/0", fwd_hit1, fwd_data1); end
    fwd_addr1 = '0; fwd_addr2 = '0;
  endtask

  task automatic test_no_write();
    logic [31:0] instrs [3];
    instrs[0] = itype(6'h04, 5'd8);
    instrs[1] = itype(6'h2B, 5'd8);
    instrs[2] = rtype(5'd0, 6'h20);
    rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = instrs[i]; in_result = 32'hDEAD0000 + i;
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL nowrite_%0d got=%b exp=0", i, rf_we); end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL nowrite_after got=%b exp=0", rf_we); end
`ifdef WB_STATS_EN
    checks++; if (drop_count !== 32'd3) begin failures++; $display("FAIL drop_count got=%0d exp=3", drop_count); end
    checks++; if (wb_count !== 32'd5) begin failures++; $display("FAIL wb_count got=%0d exp=5", wb_count); end
`endif
  endtask

  task automatic test_reset_mid_stall();
    rf_ready = 1'b0;
    in_valid = 1'b1; in_instr = rtype(5'd10, 6'h20); in_result = 32'hA;
    tick();
    in_instr = rtype(5'd11, 6'h21); in_result = 32'hB;
    tick();
    in_valid = 1'b0;
    fwd_addr1 = 5'd10;
    checks++; if (in_ready !== 1'b0 || rf_we !== 1'b1) begin failures++; $display("FAIL rst_pre_full got=%b/%b exp=0/1", in_ready, rf_we); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_async_rf_we got=%b exp=0", rf_we); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_async_in_ready got=%b exp=1", in_ready); end
    checks++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0) begin failures++; $display("FAIL rst_async_fwd got=%b/%h exp=0/0", fwd_hit1, fwd_data1); end
    tick();
    reset = 1'b1;
    rf_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_stale_%0d got=%b addr=%0d exp=0", i, rf_we, rf_waddr); end
    end
    in_valid = 1'b1; in_instr = rtype(5'd4, 6'h20); in_result = 32'h44;
    tick();
    in_valid = 1'b0;
    checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin failures++; $display("FAIL rst_resume got=%b/%0d/%h exp=1/4/44", rf_we, rf_waddr, rf_wdata); end
    fwd_addr1 = '0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_full_stall();
    test_forwarding();
    test_no_write();
    test_reset_mid_stall();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
